// File: rtl/dcache_miss_ctrl_if.sv
// Bus bundle for the dcache miss controller: lookup handshake, tag RAM
// access, line fill handshake and invalidate-all command.
interface dcache_miss_ctrl_if #(
   parameter int AWID = 32
);
   logic                       req_valid;
   logic [AWID-1:0]            req_adr;
   logic                       req_ready;
   logic                       resp_valid;
   logic                       resp_hit;
   logic [1:0]                 resp_way;
   logic [6:0]                 tag_ndx;
   logic [3:0][AWID-7:0]       tag_rd;
   logic                       tag_wr;
   logic [AWID-1:0]            tag_adr;
   logic [1:0]                 tag_way;
   logic                       fill_req;
   logic [AWID-1:0]            fill_adr;
   logic                       fill_ack;
   logic                       inval_req;
   logic                       inval_done;

   // master: requester / memory side; slave: the miss controller
   modport master (
      output req_valid, req_adr, tag_rd, fill_ack, inval_req,
      input  req_ready, resp_valid, resp_hit, resp_way, tag_ndx,
             tag_wr, tag_adr, tag_way, fill_req, fill_adr, inval_done
   );
   modport slave (
      input  req_valid, req_adr, tag_rd, fill_ack, inval_req,
      output req_ready, resp_valid, resp_hit, resp_way, tag_ndx,
             tag_wr, tag_adr, tag_way, fill_req, fill_adr, inval_done
   );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// 4-way data cache miss controller: tag lookup, victim selection (invalid
// first, then per-set round robin), line fill, tag update, invalidate-all.
module dcache_miss_ctrl #(
   parameter int LINES = 128,
   parameter int WAYS  = 4,
   parameter int AWID  = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   dcache_miss_ctrl_if.slave bus
);
   localparam int IW = $clog2(LINES);

   typedef enum logic [2:0] {IDLE, LOOKUP, FILL, UPDATE, INVAL} state_t;

   state_t                   state, state_nx;
   logic [AWID-1:0]          adr_q;
   logic [1:0]               victim;
   logic                     victim_rr;
   logic [IW-1:0]            cnt;
   logic [WAYS-1:0][LINES-1:0] valid;
   logic [LINES-1:0][1:0]    rr;

   logic [IW-1:0]            ndx;
   logic [WAYS-1:0]          hit_vec, inv_vec;
   logic                     hit;
   logic [1:0]               hit_way, lk_victim;
   logic                     lk_from_rr;

   assign ndx = adr_q[7 +: IW];

   for (genvar w = 0; w < WAYS; w++) begin : g_way
      assign hit_vec[w] = valid[w][ndx] && (bus.tag_rd[w] == adr_q[AWID-1:6]);
      assign inv_vec[w] = !valid[w][ndx];
   end

   // Lowest way wins for both hit resolution and invalid-way victim pick
   always_comb begin
      hit        = |hit_vec;
      hit_way    = 2'd0;
      lk_victim  = rr[ndx];
      lk_from_rr = 1'b1;
      for (int w = WAYS-1; w >= 0; w--) begin
         if (hit_vec[w]) hit_way = 2'(w);
         if (inv_vec[w]) begin
            lk_victim  = 2'(w);
            lk_from_rr = 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (bus.inval_req)      state_nx = INVAL;
                  else if (bus.req_valid) state_nx = LOOKUP;
         LOOKUP:  state_nx = hit ? IDLE : FILL;
         FILL:    if (bus.fill_ack) state_nx = UPDATE;
         UPDATE:  state_nx = IDLE;
         INVAL:   if (cnt == '1) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // Outputs are forced quiet while reset is held, even though state is IDLE
   always_comb begin
      bus.req_ready  = 1'b0;
      bus.resp_valid = 1'b0;
      bus.resp_hit   = 1'b0;
      bus.resp_way   = 2'd0;
      bus.tag_ndx    = '0;
      bus.tag_wr     = 1'b0;
      bus.tag_adr    = '0;
      bus.tag_way    = 2'd0;
      bus.fill_req   = 1'b0;
      bus.fill_adr   = '0;
      bus.inval_done = 1'b0;
      if (rst_n) begin
         case (state)
            IDLE: begin
               bus.req_ready = !bus.inval_req;
               bus.tag_ndx   = bus.req_adr[7 +: IW];
            end
            LOOKUP: begin
               bus.tag_ndx = ndx;
               if (hit) begin
                  bus.resp_valid = 1'b1;
                  bus.resp_hit   = 1'b1;
                  bus.resp_way   = hit_way;
               end
            end
            FILL: begin
               bus.tag_ndx  = ndx;
               bus.fill_req = 1'b1;
               bus.fill_adr = {adr_q[AWID-1:6], 6'b0};
            end
            UPDATE: begin
               bus.tag_ndx    = ndx;
               bus.tag_wr     = 1'b1;
               bus.tag_adr    = adr_q;
               bus.tag_way    = victim;
               bus.resp_valid = 1'b1;
               bus.resp_way   = victim;
            end
            INVAL: begin
               bus.tag_ndx    = cnt;
               bus.inval_done = (cnt == '1);
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         adr_q     <= '0;
         victim    <= 2'd0;
         victim_rr <= 1'b0;
         cnt       <= '0;
         valid     <= '0;
         rr        <= '0;
      end else begin
         case (state)
            IDLE: if (!bus.inval_req && bus.req_valid) adr_q <= bus.req_adr;
            LOOKUP: if (!hit) begin
               victim    <= lk_victim;
               victim_rr <= lk_from_rr;
            end
            UPDATE: begin
               valid[victim][ndx] <= 1'b1;
               if (victim_rr) rr[ndx] <= rr[ndx] + 2'd1;
            end
            INVAL: begin
               for (int w = 0; w < WAYS; w++) valid[w][cnt] <= 1'b0;
               cnt <= cnt + 1'b1;
               if (cnt == '1) rr <= '0;
            end
            default: ;
         endcase
      end
   end
endmodule
